// File: rtl/gate_model_misr.sv
// gate_model_misr
//   Response compactor for the combinational gate models. Each accepted
//   10-bit response vector is folded into a Galois-style multiple-input
//   signature register. After the requested number of vectors the block
//   reports the final signature and whether it matches the golden value.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a run (accepted only in IDLE and DONE)
//   num_vec    in   vectors to compact, latched on an accepted start
//   expected   in   golden signature, latched on an accepted start
//   resp_valid in   response vector present
//   resp       in   {N423,N422,N421,N420,N419,N418,N416,N415,N414,N408}
//   resp_ready out  block accepts resp this cycle
//   busy       out  run in progress
//   done       out  run complete, result outputs valid
//   pass       out  signature == expected, meaningful only while done=1
//   signature  out  current MISR contents
//   vec_count  out  vectors accepted in the current run
module gate_model_misr #(
  parameter int unsigned             WIDTH   = 10,
  parameter logic [WIDTH-1:0]        POLY    = 10'h009,
  parameter logic [WIDTH-1:0]        SEED    = 10'h000,
  parameter int unsigned             COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] num_vec,
  input  logic [WIDTH-1:0]   expected,
  input  logic               resp_valid,
  input  logic [WIDTH-1:0]   resp,
  output logic               resp_ready,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [WIDTH-1:0]   signature,
  output logic [COUNT_W-1:0] vec_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic [COUNT_W-1:0] num_q, num_d;
  logic [WIDTH-1:0]   exp_q, exp_d;

  logic [WIDTH-1:0]   sig_next;
  logic [COUNT_W-1:0] cnt_next;

  // Galois step: shift left, fold the outgoing MSB back through the taps,
  // then mix in the new response vector.
  always_comb begin
    sig_next = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? POLY : '0) ^ resp;
    cnt_next = cnt_q + COUNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    exp_d   = exp_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          sig_d   = SEED;
          cnt_d   = '0;
          num_d   = num_vec;
          exp_d   = expected;
          state_d = (num_vec == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (resp_valid) begin
          sig_d = sig_next;
          cnt_d = cnt_next;
          // Comparing the post-increment count against num avoids a
          // num-1 subtraction; num is nonzero whenever RUN is entered.
          if (cnt_next == num_q) begin
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
      num_q   <= '0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      exp_q   <= exp_d;
    end
  end

  always_comb begin
    resp_ready = (state_q == RUN);
    busy       = (state_q == RUN);
    done       = (state_q == DONE);
    pass       = (state_q == DONE) && (sig_q == exp_q);
    signature  = sig_q;
    vec_count  = cnt_q;
  end

endmodule

// File: tb/tb_gate_model_misr.sv
module tb_gate_model_misr;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_vec;
  logic [9:0]  expected;
  logic        resp_valid;
  logic [9:0]  resp;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic [9:0]  signature;
  logic [15:0] vec_count;

  int total = 0;
  int bad   = 0;

  gate_model_misr #(
    .WIDTH   (10),
    .POLY    (10'h009),
    .SEED    (10'h000),
    .COUNT_W (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vec    (num_vec),
    .expected   (expected),
    .resp_valid (resp_valid),
    .resp       (resp),
    .resp_ready (resp_ready),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature),
    .vec_count  (vec_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [15:0] n, input logic [9:0] e);
    start = 1'b1; num_vec = n; expected = e;
    tick();
    start = 1'b0;
  endtask

  task automatic xfer(input logic [9:0] v);
    resp_valid = 1'b1; resp = v;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (busy !== 1'b0 || done !== 1'b0 || resp_ready !== 1'b0 || pass !== 1'b0) begin
      bad++; $display("FAIL reset_ctrl got busy=%b done=%b rdy=%b pass=%b want 0000", busy, done, resp_ready, pass);
    end
    total++; if (signature !== 10'h000 || vec_count !== 16'd0) begin
      bad++; $display("FAIL reset_data got sig=%h cnt=%0d want 000/0", signature, vec_count);
    end
    // Reset mid-run, with start asserted in the same cycle: reset wins.
    do_start(16'd4, 10'h000);
    xfer(10'h155);
    total++; if (signature !== 10'h155 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_prerun got sig=%h busy=%b want 155/1", signature, busy);
    end
    rst = 1'b1; start = 1'b1; num_vec = 16'd2;
    tick();
    rst = 1'b0; start = 1'b0;
    total++; if (signature !== 10'h000 || vec_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || resp_ready !== 1'b0) begin
      bad++; $display("FAIL reset_midrun got sig=%h cnt=%0d busy=%b done=%b rdy=%b want 000/0/0/0/0",
                      signature, vec_count, busy, done, resp_ready);
    end
  endtask

  task automatic test_single();
    do_start(16'd1, 10'h155);
    total++; if (busy !== 1'b1 || resp_ready !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL single_start got busy=%b rdy=%b done=%b want 110", busy, resp_ready, done);
    end
    xfer(10'h155);
    total++; if (signature !== 10'h155 || done !== 1'b1 || pass !== 1'b1 || vec_count !== 16'd1 || resp_ready !== 1'b0) begin
      bad++; $display("FAIL single_result got sig=%h done=%b pass=%b cnt=%0d rdy=%b want 155/1/1/1/0",
                      signature, done, pass, vec_count, resp_ready);
    end
  endtask

  task automatic test_feedback();
    do_start(16'd2, 10'h3F7);
    xfer(10'h3FF);
    total++; if (signature !== 10'h3FF || done !== 1'b0) begin
      bad++; $display("FAIL fb_first got sig=%h done=%b want 3ff/0", signature, done);
    end
    xfer(10'h000);
    total++; if (signature !== 10'h3F7 || done !== 1'b1 || pass !== 1'b1) begin
      bad++; $display("FAIL fb_pass got sig=%h done=%b pass=%b want 3f7/1/1", signature, done, pass);
    end
    do_start(16'd2, 10'h3F6);
    xfer(10'h3FF);
    xfer(10'h000);
    total++; if (signature !== 10'h3F7 || done !== 1'b1 || pass !== 1'b0) begin
      bad++; $display("FAIL fb_fail got sig=%h done=%b pass=%b want 3f7/1/0", signature, done, pass);
    end
  endtask

  task automatic test_gaps();
    // 0x155 -> 0x2AB -> 0x35F
    do_start(16'd3, 10'h35F);
    xfer(10'h155);
    resp = 10'h3C3;
    tick(); tick();
    total++; if (signature !== 10'h155 || vec_count !== 16'd1 || resp_ready !== 1'b1) begin
      bad++; $display("FAIL gap_hold1 got sig=%h cnt=%0d rdy=%b want 155/1/1", signature, vec_count, resp_ready);
    end
    xfer(10'h001);
    tick(); tick();
    total++; if (signature !== 10'h2AB || vec_count !== 16'd2) begin
      bad++; $display("FAIL gap_hold2 got sig=%h cnt=%0d want 2ab/2", signature, vec_count);
    end
    xfer(10'h200);
    total++; if (signature !== 10'h35F || done !== 1'b1 || pass !== 1'b1 || vec_count !== 16'd3) begin
      bad++; $display("FAIL gap_final got sig=%h done=%b pass=%b cnt=%0d want 35f/1/1/3", signature, done, pass, vec_count);
    end
    // Same vectors without gaps.
    do_start(16'd3, 10'h35F);
    xfer(10'h155); xfer(10'h001); xfer(10'h200);
    total++; if (signature !== 10'h35F || pass !== 1'b1) begin
      bad++; $display("FAIL nogap_final got sig=%h pass=%b want 35f/1", signature, pass);
    end
    // DONE ignores resp_valid.
    xfer(10'h3FF);
    total++; if (signature !== 10'h35F || vec_count !== 16'd3 || done !== 1'b1) begin
      bad++; $display("FAIL done_hold got sig=%h cnt=%0d done=%b want 35f/3/1", signature, vec_count, done);
    end
  endtask

  task automatic test_zero_restart();
    do_start(16'd0, 10'h000);
    total++; if (done !== 1'b1 || busy !== 1'b0 || signature !== 10'h000 || vec_count !== 16'd0 || pass !== 1'b1) begin
      bad++; $display("FAIL zero_len got done=%b busy=%b sig=%h cnt=%0d pass=%b want 1/0/000/0/1",
                      done, busy, signature, vec_count, pass);
    end
    do_start(16'd1, 10'h3FF);
    total++; if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL restart got busy=%b done=%b want 1/0", busy, done);
    end
    // start mid-run must not relatch or clear anything.
    do_start(16'd5, 10'h000);
    total++; if (busy !== 1'b1 || vec_count !== 16'd0) begin
      bad++; $display("FAIL midrun_start got busy=%b cnt=%0d want 1/0", busy, vec_count);
    end
    xfer(10'h3FF);
    total++; if (done !== 1'b1 || signature !== 10'h3FF || vec_count !== 16'd1 || pass !== 1'b1) begin
      bad++; $display("FAIL midrun_end got done=%b sig=%h cnt=%0d pass=%b want 1/3ff/1/1", done, signature, vec_count, pass);
    end
  endtask

  task automatic test_back_to_back();
    int xfers = 0;
    int first = -1;
    int last  = -1;
    // One 0x001 then zeros: result is x^15 mod (x^10+x^3+1) = x^8+x^5 = 0x120.
    do_start(16'd16, 10'h120);
    resp_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      resp = (c == 0) ? 10'h001 : 10'h000;
      if (resp_ready === 1'b1) begin
        xfers++;
        if (first < 0) first = c;
        last = c;
      end
      tick();
      if (c == 15) begin
        total++; if (done !== 1'b1 || resp_ready !== 1'b0 || signature !== 10'h120 || pass !== 1'b1) begin
          bad++; $display("FAIL b2b_end got done=%b rdy=%b sig=%h pass=%b want 1/0/120/1", done, resp_ready, signature, pass);
        end
      end
    end
    resp_valid = 1'b0;
    total++; if (xfers != 16 || first != 0 || last != 15) begin
      bad++; $display("FAIL b2b_count got xfers=%0d first=%0d last=%0d want 16/0/15", xfers, first, last);
    end
    total++; if (vec_count !== 16'd16) begin
      bad++; $display("FAIL b2b_vec_count got %0d want 16", vec_count);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; num_vec = '0; expected = '0; resp_valid = 1'b0; resp = '0;
    test_reset();
    test_single();
    test_feedback();
    test_gaps();
    test_zero_restart();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_model_misr.md
# gate_model_misr

Downstream response compactor for the combinational gate models in the gate library. It consumes one 10-bit output vector per handshake (N408, N414–N416, N418–N423 in a fixed bit order) and folds it into a multiple-input signature register (MISR). After a programmed number of vectors it reports the final signature and a pass/fail compare against an expected value. It sits between the gate model's outputs and the lab simulator's result readout.

## Interface
Parameters:
- WIDTH, 10, response/signature width (one bit per gate-model output)
- POLY, 10'h009, Galois feedback taps (x^10 + x^3 + 1, primitive)
- SEED, 10'h000, signature value loaded at start
- COUNT_W, 16, width of vector count

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a run; honoured in IDLE and DONE only
- num_vec  in  COUNT_W  vectors to compact; sampled when start is accepted
- expected  in  WIDTH  golden signature; sampled when start is accepted
- resp_valid  in  1  response vector present
- resp  in  WIDTH  response vector; bit order {N423,N422,N421,N420,N419,N418,N416,N415,N414,N408}
- resp_ready  out  1  block accepts resp this cycle
- busy  out  1  run in progress
- done  out  1  run complete; result outputs valid
- pass  out  1  signature == expected; valid only while done=1
- signature  out  WIDTH  current MISR contents
- vec_count  out  COUNT_W  vectors accepted in the current run

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: resp_ready=0, busy=0, done=0. On start: signature<=SEED, vec_count<=0, latch num_vec and expected. If num_vec==0, go to DONE; otherwise go to RUN.
- RUN: resp_ready=1, busy=1. A transfer occurs when resp_valid && resp_ready. On a transfer: signature <= ({signature[WIDTH-2:0],1'b0} ^ (signature[WIDTH-1] ? POLY : 0)) ^ resp, truncated to WIDTH bits; vec_count increments. The transfer where vec_count == latched num_vec−1 moves the FSM to DONE. With resp_valid=0, state is held. start is ignored in RUN.
- DONE: resp_ready=0, busy=0, done=1, pass=(signature==latched expected), all held stable. start re-enters the IDLE start action (new seed, count and latches) and moves the FSM to RUN, or to DONE if num_vec==0. resp_valid is ignored.
- vec_count never wraps within a run, because a run ends at num_vec ≤ 2^COUNT_W−1.

## Timing
- Reset values: state IDLE, resp_ready=0, busy=0, done=0, pass=0, signature=SEED, vec_count=0.
- start sampled at edge k: busy=1 and resp_ready=1 from cycle k+1.
- Throughput: one vector per cycle while resp_valid stays high.
- Last transfer at edge m: signature holds the final value and done=1, pass valid, resp_ready=0 from cycle m+1. No extra latency.
- num_vec==0: done=1 and signature=SEED one cycle after start.
- rst asserted at any point, including mid-RUN: next cycle all outputs return to reset values. The partial signature is discarded.
- start and rst in the same cycle: rst wins.

## Test plan
- Reset: assert rst during RUN with signature≠0 -> next cycle state IDLE, signature=0x000, vec_count=0, done=0, resp_ready=0.
- Single vector: num_vec=1, expected=0x155, resp=0x155 -> signature=0x155, done=1 one cycle after transfer, pass=1, vec_count=1.
- Feedback: num_vec=2, responses 0x3FF then 0x000, expected=0x3F7 -> signature 0x3FF then 0x3F7, pass=1. Repeat with expected=0x3F6 -> pass=0.
- Backpressure gaps: num_vec=3 with resp_valid low for 2 cycles between vectors -> signature and vec_count hold during gaps, final signature equals the gap-free run.
- Zero length and restart: start with num_vec=0 -> done=1, signature=SEED next cycle. start again from DONE with num_vec=1 -> busy=1, done=0 next cycle. start pulsed mid-RUN -> ignored, vec_count unaffected.
- Back-to-back throughput: num_vec=16 with resp_valid held high -> exactly 16 transfers in 16 consecutive cycles, resp_ready drops the cycle after the 16th transfer, done=1.
